// File: rtl/rx_os_counter_bank.sv
// ---------------------------------------------------------------------------
// rx_os_counter_bank
//
// Per-lane consecutive ordered-set counter bank on the receive path, feeding
// the master RX LTSSM. Each lane counts back-to-back ordered sets that are
// acceptable for the current LTSSM substate. It reports one registered flag
// per lane showing whether that lane's count has reached the shared target.
//
// Ports
//   clk                    clock
//   reset                  asynchronous, active-low reset
//   i_substate[3:0]        current LTSSM substate
//   i_resetOsCheckers[15:0] per-lane run enable (0 = hold count and flag at 0)
//   i_comparatorsCount[4:0] target consecutive count, shared by all lanes
//   i_osValid[MAXLANES]    one-cycle strobe per lane, one decoded ordered set
//   i_osType[2*MAXLANES]   lane i at [2i+1:2i]: 00 TS1, 01 TS2, 10 IDLE, 11 other
//   i_osInfo[16*MAXLANES]  lane i at [16i+15:16i]: {link number, lane number}
//   o_countersComparators[15:0] per-lane "count >= target", registered;
//                          bits at MAXLANES and above are tied to 0
// ---------------------------------------------------------------------------
module rx_os_counter_bank #(
   parameter int MAXLANES = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [3:0]              i_substate,
   input  logic [15:0]             i_resetOsCheckers,
   input  logic [4:0]              i_comparatorsCount,
   input  logic [MAXLANES-1:0]     i_osValid,
   input  logic [2*MAXLANES-1:0]   i_osType,
   input  logic [16*MAXLANES-1:0]  i_osInfo,
   output logic [15:0]             o_countersComparators
);

   // LTSSM substate encodings
   localparam logic [3:0] SUB_DETECT_QUIET      = 4'd0;
   localparam logic [3:0] SUB_DETECT_ACTIVE     = 4'd1;
   localparam logic [3:0] SUB_POLLING_ACTIVE    = 4'd2;
   localparam logic [3:0] SUB_POLLING_CONFIG    = 4'd3;
   localparam logic [3:0] SUB_CFG_LW_START      = 4'd4;
   localparam logic [3:0] SUB_CFG_LW_ACCEPT     = 4'd5;
   localparam logic [3:0] SUB_CFG_LANENUM_WAIT  = 4'd6;
   localparam logic [3:0] SUB_CFG_LANENUM_ACC   = 4'd7;
   localparam logic [3:0] SUB_CFG_COMPLETE      = 4'd8;
   localparam logic [3:0] SUB_CFG_IDLE          = 4'd9;
   localparam logic [3:0] SUB_L0                = 4'd10;

   // Ordered-set type encodings
   localparam logic [1:0] OS_TS1   = 2'b00;
   localparam logic [1:0] OS_TS2   = 2'b01;
   localparam logic [1:0] OS_IDLE  = 2'b10;

   localparam logic [4:0] CNT_MAX  = 5'd31;
   localparam logic [3:0] PREV_SUB_RESET = 4'hF;

   logic [3:0] r_prevSub;
   logic       w_subChange;
   logic       w_acceptTs1;
   logic       w_acceptTs2;
   logic       w_acceptIdle;
   logic       w_idCheck;

   // Registered copy of the substate. Comparing the live substate against it
   // lets every lane clear on the first edge of a new substate. The reset
   // value is an unused encoding, so the first edge after reset always counts
   // as a change.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_prevSub <= PREV_SUB_RESET;
      end else begin
         r_prevSub <= i_substate;
      end
   end

   assign w_subChange = (i_substate != r_prevSub);

   // Substate decode: which ordered-set types may extend a run, and whether
   // link/lane identity must stay constant across the run. Detect, L0 and the
   // unused encodings accept nothing, so every strobe there resets the count.
   always_comb begin
      w_acceptTs1  = 1'b0;
      w_acceptTs2  = 1'b0;
      w_acceptIdle = 1'b0;
      w_idCheck    = 1'b0;
      case (i_substate)
         SUB_POLLING_ACTIVE: begin
            w_acceptTs1 = 1'b1;
            w_acceptTs2 = 1'b1;
         end
         SUB_POLLING_CONFIG: begin
            w_acceptTs2 = 1'b1;
         end
         SUB_CFG_LW_START, SUB_CFG_LW_ACCEPT,
         SUB_CFG_LANENUM_WAIT, SUB_CFG_LANENUM_ACC: begin
            w_acceptTs1 = 1'b1;
            w_idCheck   = 1'b1;
         end
         SUB_CFG_COMPLETE: begin
            w_acceptTs2 = 1'b1;
            w_idCheck   = 1'b1;
         end
         SUB_CFG_IDLE: begin
            w_acceptIdle = 1'b1;
         end
         SUB_DETECT_QUIET, SUB_DETECT_ACTIVE, SUB_L0: begin
            w_acceptTs1 = 1'b0;
         end
         default: begin
            w_acceptTs1 = 1'b0;
         end
      endcase
   end

   for (genvar g = 0; g < 16; g++) begin : gLane
      if (g < MAXLANES) begin : gLive
         logic [1:0]  w_type;
         logic [15:0] w_info;
         logic        w_typeOk;
         logic        w_enable;
         logic [4:0]  w_cntNext;
         logic [15:0] w_lastInfoNext;
         logic        w_flagNext;
         logic [4:0]  r_cnt;
         logic [15:0] r_lastInfo;
         logic        r_flag;

         assign w_type   = i_osType[2*g +: 2];
         assign w_info   = i_osInfo[16*g +: 16];
         assign w_enable = i_resetOsCheckers[g];

         // Type acceptance for this lane's ordered set in the current substate.
         always_comb begin
            w_typeOk = 1'b0;
            case (w_type)
               OS_TS1:  w_typeOk = w_acceptTs1;
               OS_TS2:  w_typeOk = w_acceptTs2;
               OS_IDLE: w_typeOk = w_acceptIdle;
               default: w_typeOk = 1'b0;
            endcase
         end

         // Next-state for the run counter and the remembered identity.
         // A set whose identity differs from the previous one in the run does
         // not break the run to zero. It starts a new run of length one,
         // because it is itself a valid first set of the new identity.
         always_comb begin
            w_cntNext      = r_cnt;
            w_lastInfoNext = r_lastInfo;
            if (!w_enable || w_subChange) begin
               w_cntNext      = 5'd0;
               w_lastInfoNext = 16'h0000;
            end else if (!i_osValid[g]) begin
               w_cntNext      = r_cnt;
            end else if (!w_typeOk) begin
               w_cntNext      = 5'd0;
            end else if (w_idCheck && (r_cnt != 5'd0) && (w_info != r_lastInfo)) begin
               w_cntNext      = 5'd1;
               w_lastInfoNext = w_info;
            end else begin
               w_cntNext      = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + 5'd1;
               w_lastInfoNext = w_info;
            end
         end

         // The flag is evaluated on the next count, so it moves on the same
         // edge as the count. A target of 0 on an enabled lane is always met.
         assign w_flagNext = w_enable && (w_cntNext >= i_comparatorsCount);

         // Per-lane state registers.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               r_cnt      <= 5'd0;
               r_lastInfo <= 16'h0000;
               r_flag     <= 1'b0;
            end else begin
               r_cnt      <= w_cntNext;
               r_lastInfo <= w_lastInfoNext;
               r_flag     <= w_flagNext;
            end
         end

         assign o_countersComparators[g] = r_flag;
      end else begin : gTied
         assign o_countersComparators[g] = 1'b0;
      end
   end

endmodule

// File: tb/tb_rx_os_counter_bank.sv
// ---------------------------------------------------------------------------
// tb_rx_os_counter_bank
//
// Self-checking bench for rx_os_counter_bank. The bench keeps a behavioural
// model that applies the per-lane run rules with plain integers. A monitor
// checks the DUT against this model after every clock edge. Directed
// sequences pin known flag values and model counts. A randomized phase then
// exercises the lanes freely.
// ---------------------------------------------------------------------------
module tb_rx_os_counter_bank;

   logic         clk;
   logic         reset;
   logic [3:0]   substate;
   logic [15:0]  enables;
   logic [4:0]   target;
   logic [15:0]  osValid;
   logic [31:0]  osType;
   logic [255:0] osInfo;
   logic [15:0]  flagsOut;

   int totalChecks;
   int badChecks;
   bit monOn;

   // Behavioural model state
   int          mCnt [16];
   logic [15:0] mLast [16];
   logic [3:0]  mPrev;
   logic [15:0] mFlags;

   rx_os_counter_bank #(.MAXLANES(16)) dut (
      .clk                   (clk),
      .reset                 (reset),
      .i_substate            (substate),
      .i_resetOsCheckers     (enables),
      .i_comparatorsCount    (target),
      .i_osValid             (osValid),
      .i_osType              (osType),
      .i_osInfo              (osInfo),
      .o_countersComparators (flagsOut)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Does substate sub accept ordered-set type t?
   function automatic bit accepts(input int sub, input int t);
      case (sub)
         2:          return (t == 0) || (t == 1);
         3, 8:       return (t == 1);
         4, 5, 6, 7: return (t == 0);
         9:          return (t == 2);
         default:    return 1'b0;
      endcase
   endfunction

   // Returns a type that the given substate usually accepts.
   function automatic logic [1:0] favType(input int sub);
      case (sub)
         2:          return 2'($urandom_range(0, 1));
         3, 8:       return 2'b01;
         4, 5, 6, 7: return 2'b00;
         9:          return 2'b10;
         default:    return 2'($urandom_range(0, 3));
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
      totalChecks++;
      if (actual !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic checkModelCnt(input string name, input int lane, input int expected);
      totalChecks++;
      if (mCnt[lane] != expected) begin
         badChecks++;
         $display("[TB] FAIL %s: model count lane %0d is %0d expected %0d",
                  name, lane, mCnt[lane], expected);
      end
   endtask

   // Drive one cycle of strobes (called at a falling edge) and return at the
   // next falling edge, with the strobes removed again.
   task automatic applyStimulus(input logic [15:0] v);
      osValid = v;
      @(negedge clk);
      osValid = 16'h0000;
   endtask

   task automatic setLane(input int lane, input logic [1:0] t, input logic [15:0] inf);
      osType[2*lane +: 2]  = t;
      osInfo[16*lane +: 16] = inf;
   endtask

   // Reference model plus per-cycle comparison.
   always @(posedge clk) begin : monitor
      bit changed;
      int t;
      logic [15:0] inf;
      if (!reset) begin
         for (int i = 0; i < 16; i++) begin
            mCnt[i]  = 0;
            mLast[i] = 16'h0000;
         end
         mPrev  = 4'hF;
         mFlags = 16'h0000;
      end else begin
         changed = (substate != mPrev);
         for (int i = 0; i < 16; i++) begin
            t   = int'(osType[2*i +: 2]);
            inf = osInfo[16*i +: 16];
            if (!enables[i] || changed) begin
               mCnt[i]  = 0;
               mLast[i] = 16'h0000;
            end else if (osValid[i]) begin
               if (!accepts(int'(substate), t)) begin
                  mCnt[i] = 0;
               end else if (substate >= 4 && substate <= 8 && mCnt[i] != 0 && inf != mLast[i]) begin
                  mCnt[i]  = 1;
                  mLast[i] = inf;
               end else begin
                  mCnt[i]  = (mCnt[i] + 1 > 31) ? 31 : mCnt[i] + 1;
                  mLast[i] = inf;
               end
            end
            mFlags[i] = enables[i] && (mCnt[i] >= int'(target));
         end
         mPrev = substate;
      end
      #1;
      if (monOn) checkOutput("cycle", flagsOut, mFlags);
   end

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      totalChecks = 0;
      badChecks   = 0;
      monOn       = 1'b1;
      reset       = 1'b1;
      substate    = 4'd0;
      enables     = 16'h0000;
      target      = 5'd0;
      osValid     = 16'h0000;
      osType      = 32'h0;
      osInfo      = 256'h0;
      #1 reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("resetState", flagsOut, 16'h0000);
      reset = 1'b1;

      // Eight TS1 on lane 0 in polling active, target 8
      substate = 4'd2;
      enables  = 16'hFFFF;
      target   = 5'd8;
      applyStimulus(16'h0000);
      for (int k = 1; k <= 8; k++) begin
         applyStimulus(16'h0001);
         if (k == 7) checkOutput("pollAfter7", flagsOut, 16'h0000);
      end
      checkOutput("pollAfter8", flagsOut, 16'h0001);
      checkModelCnt("pollCnt8", 0, 8);

      // Identity check in cfgLinkWidthStart, lane 3, target 2
      substate = 4'd4;
      target   = 5'd2;
      applyStimulus(16'h0000);
      setLane(3, 2'b00, 16'h0100);
      applyStimulus(16'h0008);
      checkModelCnt("idCnt1", 3, 1);
      checkOutput("idFlag1", flagsOut, 16'h0000);
      setLane(3, 2'b00, 16'h0200);
      applyStimulus(16'h0008);
      checkModelCnt("idCnt2", 3, 1);
      checkOutput("idFlag2", flagsOut, 16'h0000);
      applyStimulus(16'h0008);
      checkModelCnt("idCnt3", 3, 2);
      checkOutput("idFlag3", flagsOut, 16'h0008);

      // Wrong type breaks the run in pollingConfiguration, lane 1
      substate = 4'd3;
      applyStimulus(16'h0000);
      setLane(1, 2'b01, 16'h0000);
      applyStimulus(16'h0002);
      checkOutput("pcFlag1", flagsOut, 16'h0000);
      applyStimulus(16'h0002);
      checkOutput("pcFlag2", flagsOut, 16'h0002);
      setLane(1, 2'b00, 16'h0000);
      applyStimulus(16'h0002);
      checkModelCnt("pcCnt3", 1, 0);
      checkOutput("pcFlag3", flagsOut, 16'h0000);
      setLane(1, 2'b01, 16'h0000);
      applyStimulus(16'h0002);
      checkModelCnt("pcCnt4", 1, 1);
      checkOutput("pcFlag4", flagsOut, 16'h0000);

      // Substate change discards a simultaneous strobe
      substate = 4'd2;
      target   = 5'd8;
      applyStimulus(16'h0000);
      setLane(0, 2'b00, 16'h0000);
      for (int k = 0; k < 5; k++) applyStimulus(16'h0001);
      checkModelCnt("chgBefore", 0, 5);
      substate = 4'd3;
      setLane(0, 2'b01, 16'h0000);
      applyStimulus(16'h0001);
      checkModelCnt("chgEdge", 0, 0);
      checkOutput("chgFlags", flagsOut, 16'h0000);
      applyStimulus(16'h0001);
      checkModelCnt("chgResume", 0, 1);

      // All lanes in cfgComplete, then disable everything
      substate = 4'd8;
      target   = 5'd8;
      osType   = 32'h5555_5555;
      for (int i = 0; i < 16; i++) osInfo[16*i +: 16] = 16'h0700 + 16'(i);
      applyStimulus(16'h0000);
      for (int k = 0; k < 8; k++) applyStimulus(16'hFFFF);
      checkOutput("allLanes", flagsOut, 16'hFFFF);
      enables = 16'h0000;
      applyStimulus(16'h0000);
      checkOutput("allDisabled", flagsOut, 16'h0000);

      // Saturation on lane 5
      enables  = 16'hFFFF;
      substate = 4'd2;
      target   = 5'd31;
      setLane(5, 2'b00, 16'h0000);
      applyStimulus(16'h0000);
      for (int k = 0; k < 30; k++) applyStimulus(16'h0020);
      checkOutput("sat30", flagsOut, 16'h0000);
      for (int k = 0; k < 10; k++) applyStimulus(16'h0020);
      checkOutput("sat40", flagsOut, 16'h0020);
      checkModelCnt("satCnt", 5, 31);

      // Target 0 in detectQuiet, then asynchronous reset mid-cycle
      substate = 4'd0;
      target   = 5'd0;
      applyStimulus(16'h0000);
      checkOutput("detectZero", flagsOut, 16'hFFFF);
      applyStimulus(16'h0000);
      #2 reset = 1'b0;
      #1 checkOutput("asyncReset", flagsOut, 16'h0000);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      // Randomized phase
      enables = 16'hFFFF;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if ($urandom_range(0, 29) == 0) begin
            if ($urandom_range(0, 4) != 0) substate = 4'($urandom_range(2, 9));
            else substate = 4'($urandom_range(0, 15));
         end
         if ($urandom_range(0, 9) == 0) begin
            if ($urandom_range(0, 7) == 0) target = 5'($urandom_range(0, 31));
            else target = 5'($urandom_range(0, 5));
         end
         if ($urandom_range(0, 14) == 0) enables[$urandom_range(0, 15)] ^= 1'b1;
         if ($urandom_range(0, 49) == 0) enables = 16'hFFFF;
         for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 3) != 0) osType[2*i +: 2] = favType(int'(substate));
            else osType[2*i +: 2] = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) osInfo[16*i +: 16] = 16'h0200 + 16'(i);
            else osInfo[16*i +: 16] = 16'h0100 + 16'(i);
         end
         applyStimulus(16'($urandom));
      end

      monOn = 1'b0;
      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
